alu_issue: RTL
==============

# alu_issue

Execute-side issue stage that produces the operand/opcode bundle consumed by the ALU. It decodes RV32I integer ALU instructions (R-type, I-type, LUI) into the shared 4-bit ALU opcode and selects operands. Decoded bundles are held in a 2-entry elastic buffer with valid/ready handshakes on both sides. It sits between the register-read stage and the ALU, and absorbs ALU-side back-pressure without dropping instructions.

## Interface
Parameters:
- DEPTH, 2, buffer entries. Fixed at 2; other values are unsupported.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous and active-high; clears all state.
- flush  input  1  synchronous; discards all buffered entries and the current input.
- in_valid  input  1  upstream holds a valid instruction.
- in_ready  output  1  buffer can accept this cycle.
- instr  input  32  instruction word.
- rs1_data  input  32  register-file value for rs1.
- rs2_data  input  32  register-file value for rs2.
- out_valid  output  1  head entry is valid.
- out_ready  input  1  ALU side consumes the head entry this cycle.
- a  output  32  ALU operand a.
- b  output  32  ALU operand b.
- alu_op  output  4  shared encoding: ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5.
- rd  output  5  destination register.
- reg_write  output  1  result must be written back.
- illegal  output  1  instruction is not a supported ALU instruction.

## Operation
- Decode is combinational on instr and is captured into the tail entry on accept, where accept = in_valid & in_ready & ~flush.
- R-type (opcode 0110011), a=rs1_data, b=rs2_data:
  - funct3 000, funct7 0000000 → ADD
  - funct3 000, funct7 0100000 → SUB
  - funct3 111, funct7 0000000 → AND
  - funct3 110, funct7 0000000 → OR
  - funct3 100, funct7 0000000 → XOR
  - funct3 001, funct7 0000000 → SLL
- I-type (opcode 0010011), a=rs1_data, b=sign-extended instr[31:20]:
  - funct3 000 → ADD; 111 → AND; 110 → OR; 100 → XOR
  - funct3 001 → SLL, only with instr[31:25]=0000000
- LUI (opcode 0110111): a=0, b={instr[31:12],12'b0}, alu_op=ADD.
- Any other encoding: illegal=1, alu_op=ADD, a=0, b=0, reg_write=0.
- rd = instr[11:7]. reg_write=1 for legal instructions with rd≠0; reg_write=0 when rd=0.
- Buffer is an in-order 2-entry FIFO with count 0..2 and 1-bit head/tail pointers that wrap.
  - in_ready = (count<2). It depends only on state, not on out_ready, so there is no combinational ready path.
  - pop = out_valid & out_ready.
  - Push and pop in the same cycle leave count unchanged and advance both pointers.
  - When full, in_ready=0 even if out_ready=1.
- out_valid = (count>0). All outputs are driven from the head entry. When empty, outputs hold the last head contents and must be ignored.
- flush: next cycle count=0 and pointers=0; any concurrent input or pop has no effect.

## Timing
- Reset (async assert): count=0, pointers=0, out_valid=0, in_ready=1, and a, b, alu_op, rd, reg_write, illegal all 0. Entry storage is cleared.
- Latency: an instruction accepted at edge N is presented with out_valid=1 after edge N. There is no same-cycle bypass.
- Throughput: one instruction per cycle when out_ready is held at 1.
- Output stability: outputs hold stable while out_valid=1 and out_ready=0.
- rst asserted mid-stream drops all entries immediately. The first accept after deassertion is at the first edge with rst=0.
- flush has priority over push and pop. rst has priority over flush.

## Test plan
- Reset then idle: out_valid=0, in_ready=1, all outputs 0; release reset → no change.
- instr 0x40208133 (sub x2,x1,x2), rs1=10, rs2=3, out_ready=1 → next cycle out_valid=1, alu_op=1, a=10, b=3, rd=2, reg_write=1, illegal=0.
- Stream of addi x5,x0,-1 (0xFFF00293) → a=0, b=0xFFFFFFFF, alu_op=0. Then lui x7,0x12345 → a=0, b=0x12345000. Then 0x00000000 → illegal=1, reg_write=0.
- Back-pressure: out_ready=0, push 3 instructions → in_ready drops after 2 accepts. Third is held upstream. Raise out_ready → order preserved, third accepted, no loss or duplication.
- Full buffer plus flush with in_valid=1 → next cycle count=0, out_valid=0, concurrent input dropped.
- add x0,x1,x2 (0x00208033) → alu_op=0, reg_write=0; slli with instr[31:25]=0100000 → illegal=1.

Source files
------------

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
//
// Issue stage between register read and the ALU. The stage decodes RV32I
// integer ALU instructions (R-type, I-type and LUI) into the shared 4-bit ALU
// opcode and selects the operands. Decoded bundles wait in a 2-entry in-order
// elastic buffer, so back-pressure from the ALU never drops an instruction.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset; clears all state and storage
//   flush      synchronous; empties the buffer and discards the current input
//   in_valid   upstream presents an instruction
//   in_ready   buffer can take an instruction this cycle
//   instr      32-bit instruction word
//   rs1_data   register-file value for rs1
//   rs2_data   register-file value for rs2
//   out_valid  head entry holds a live bundle
//   out_ready  ALU consumes the head entry this cycle
//   a, b       ALU operands
//   alu_op     ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5
//   rd         destination register (instr[11:7])
//   reg_write  result must be written back (legal and rd != 0)
//   illegal    instruction is not a supported ALU instruction
//
// Handshake: a transfer occurs on a rising edge where valid and ready are
// both 1. in_ready depends only on the buffer occupancy, never on out_ready,
// so no combinational path runs from the ALU back to the register-read stage.
// flush blocks both transfers in the cycle it is asserted.
// -----------------------------------------------------------------------------
module alu_issue #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  alu_op,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic        illegal
);

  // Shared ALU opcode encoding
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLL = 4'd5;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // The pointers are single bits, so the buffer only works with two entries.
  localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;
  } entry_t;

  // ---------------------------------------------------------------------------
  // Decode (combinational on instr)
  // ---------------------------------------------------------------------------
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] dec_rd;

  assign opcode = instr[6:0];
  assign dec_rd = instr[11:7];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Register indices were already resolved by the register-read stage.
  logic unused_rs_fields;
  assign unused_rs_fields = ^instr[19:15];

  logic [31:0] imm_i;
  logic [31:0] imm_u;
  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};

  logic [3:0]  dec_op;
  logic        dec_legal;
  logic [31:0] raw_a;
  logic [31:0] raw_b;

  always_comb begin
    dec_op    = OP_ADD;
    dec_legal = 1'b0;
    raw_a     = '0;
    raw_b     = '0;
    case (opcode)
      OPC_OP: begin
        raw_a = rs1_data;
        raw_b = rs2_data;
        case (funct3)
          3'b000: begin
            if (funct7 == 7'b0000000) begin
              dec_op    = OP_ADD;
              dec_legal = 1'b1;
            end else if (funct7 == 7'b0100000) begin
              dec_op    = OP_SUB;
              dec_legal = 1'b1;
            end
          end
          3'b111: begin
            dec_op    = OP_AND;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b110: begin
            dec_op    = OP_OR;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b100: begin
            dec_op    = OP_XOR;
            dec_legal = (funct7 == 7'b0000000);
          end
          3'b001: begin
            dec_op    = OP_SLL;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        raw_a = rs1_data;
        raw_b = imm_i;
        case (funct3)
          3'b000: begin
            dec_op    = OP_ADD;
            dec_legal = 1'b1;
          end
          3'b111: begin
            dec_op    = OP_AND;
            dec_legal = 1'b1;
          end
          3'b110: begin
            dec_op    = OP_OR;
            dec_legal = 1'b1;
          end
          3'b100: begin
            dec_op    = OP_XOR;
            dec_legal = 1'b1;
          end
          3'b001: begin
            // slli only exists with a zero upper immediate; other forms are
            // shift variants this ALU does not implement.
            dec_op    = OP_SLL;
            dec_legal = (funct7 == 7'b0000000);
          end
          default: dec_legal = 1'b0;
        endcase
      end
      OPC_LUI: begin
        raw_a     = '0;
        raw_b     = imm_u;
        dec_op    = OP_ADD;
        dec_legal = 1'b1;
      end
      default: dec_legal = 1'b0;
    endcase
  end

  // Illegal encodings collapse to a harmless ADD of zeros with no writeback.
  entry_t dec_entry;
  always_comb begin
    dec_entry           = '0;
    dec_entry.a         = dec_legal ? raw_a : 32'd0;
    dec_entry.b         = dec_legal ? raw_b : 32'd0;
    dec_entry.alu_op    = dec_legal ? dec_op : OP_ADD;
    dec_entry.rd        = dec_rd;
    dec_entry.reg_write = dec_legal && (dec_rd != 5'd0);
    dec_entry.illegal   = ~dec_legal;
  end

  // ---------------------------------------------------------------------------
  // Two-entry in-order buffer
  // ---------------------------------------------------------------------------
  entry_t     mem [2];
  logic [1:0] count;
  logic       head;
  logic       tail;
  logic       push;
  logic       pop;

  assign in_ready  = (count < FULL_COUNT);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= 2'd0;
      head   <= 1'b0;
      tail   <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      // Storage is left alone; with count at zero its contents are dead.
      count <= 2'd0;
      head  <= 1'b0;
      tail  <= 1'b0;
    end else begin
      if (push) begin
        mem[tail] <= dec_entry;
        tail      <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Outputs come straight from the head entry; when empty they show stale
  // contents and out_valid=0 tells the consumer to ignore them.
  entry_t head_entry;
  assign head_entry = mem[head];

  assign a         = head_entry.a;
  assign b         = head_entry.b;
  assign alu_op    = head_entry.alu_op;
  assign rd        = head_entry.rd;
  assign reg_write = head_entry.reg_write;
  assign illegal   = head_entry.illegal;

endmodule
